pbkdf2_loader: RTL and testbench
================================

# pbkdf2_loader

Byte-stream front end for the `pbkdf2` key-derivation core. Accepts a framed 8-bit stream carrying the iteration count, password and salt. Packs the fields into the wide, zero-padded registers the core consumes, then presents them with a valid/ready handshake held stable until accepted. Malformed frames are drained and reported, and never reach the core.

## Interface
Parameters:
- `MAX_PASS`, 64: maximum password length in bytes; fixes `pass_o` width at 8*MAX_PASS.
- `MAX_SALT`, 63: maximum salt length in bytes; bounded by the 6-bit `salt_len_o`.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-low reset; asserted when 0, sampled on the rising edge of `clk_i`.
- `data_i`  in  8  stream byte.
- `v_i`  in  1  `data_i` is valid.
- `r_o`  out  1  loader can accept a byte; a byte transfers when `v_i && r_o`.
- `iters_o`  out  32  iteration count.
- `pass_o`  out  512  password, first byte in [511:504], zero-padded.
- `salt_o`  out  512  salt, first byte in [511:504], zero-padded.
- `salt_len_o`  out  6  salt length in bytes.
- `v_o`  out  1  packed parameter set is valid (drives core `in_valid`).
- `r_i`  in  1  core accepts the set (core `in_ready`).
- `err_o`  out  1  one-cycle pulse when a malformed frame finishes draining.
- `frames_o`  out  16  count of parameter sets delivered; wraps at 0xFFFF -> 0.

## Operation
- Frame format, in byte order:
  - bytes 0-3: `iters`, big-endian.
  - byte 4: `pass_len` (P).
  - byte 5: `salt_len` (S).
  - next P bytes: password.
  - next S bytes: salt.
- States and transitions:
  - HDR: collects 6 header bytes with a byte counter.
  - PASS: collects P bytes.
  - SALT: collects S bytes.
  - HOLD: presents outputs.
  - DRAIN: discards P+S bytes.
- Acceptance of header byte 0 clears `pass_o`, `salt_o`, `iters_o` and `salt_len_o` to 0, so unfilled bytes are always zero.
- Byte k of a field (k from 0) is written to bits [511-8k -: 8] of that field.
- Header check, applied at acceptance of byte 5. A frame is malformed when any of these hold:
  - `iters == 0`
  - `S == 0`
  - `S > MAX_SALT`
  - `P > MAX_PASS`
- Routing after byte 5:
  - Malformed frame -> DRAIN, with a 9-bit remaining counter loaded with P+S.
  - P == 0 -> SALT directly.
  - Otherwise -> PASS.
- PASS -> SALT after the P-th password byte; SALT -> HOLD after the S-th salt byte.
- DRAIN: accepts and discards bytes until the counter reaches 0, then goes to HDR and pulses `err_o` for one cycle. If P+S == 0, the pulse and the move to HDR happen on the cycle after byte 5.
- `r_o` = 1 in HDR, PASS, SALT and DRAIN; `r_o` = 0 in HOLD and during reset.
- HOLD:
  - `v_o` = 1, and all data outputs are stable.
  - On `v_o && r_i`: go to HDR and increment `frames_o`.
  - `v_o` deasserts the cycle after the transfer.
- Outputs keep their values after the handshake until the next header byte 0 is accepted.

## Timing
- Reset values: `r_o`=0, `v_o`=0, `err_o`=0, `frames_o`=0, all data outputs 0; state HDR.
- `r_o`=1 in the first cycle after reset deasserts.
- One byte per cycle maximum; no bubbles are introduced while `v_i` stays high.
- Latency: `v_o` asserts in the cycle after the last salt byte is accepted.
- Frame of P+S+6 bytes at full rate: `v_o` high at cycle P+S+6, counting from 0 at the byte-0 acceptance cycle.
- Back-to-back transfer: `r_o` returns to 1 in the cycle after `v_o && r_i`.
- `v_i` low mid-frame stalls without state change; the byte counters hold.
- Reset asserted mid-frame or in HOLD: all state and outputs return to reset values on that edge, and the partial frame is lost.
- `r_i` high while `v_o` = 0 has no effect.

## Test plan
- Nominal frame: iters=0x00001000, P=8 ("password"), S=4 ("salt") -> `v_o` at cycle 18; `pass_o`[511:448]=0x70617373776F7264, rest 0; `salt_o`[511:480]=0x73616C74, rest 0; `salt_len_o`=4; `frames_o`=1 after `r_i`.
- Backpressure: hold `r_i`=0 for 10 cycles in HOLD -> `v_o` and all outputs stable, `r_o`=0, input bytes not consumed; `r_i`=1 -> transfer, `r_o`=1 next cycle.
- P=0, S=63 of 0xA5, iters=1 -> PASS skipped; `pass_o`=0; `salt_o`[511:8]=all 0xA5, [7:0]=0; `salt_len_o`=63.
- Malformed frames:
  - iters=0, P=2, S=3 -> exactly 5 body bytes drained, then `err_o` pulses once, `v_o` never asserts, `frames_o` unchanged.
  - S=64 -> same drain-and-error behaviour.
  - Next valid frame is then delivered correctly.
- Random `v_i` gaps on a P=64, S=16 frame -> results identical to the full-rate run.
- Reset pulse at byte 20 of a frame -> all outputs 0; a following clean frame is delivered with `frames_o`=1. Separately, force 65536 deliveries -> `frames_o` wraps to 0.

Source files
------------

// File: rtl/pbkdf2_loader.sv
// Byte-stream front end for the pbkdf2 core. Parses a framed stream
// (iters, pass_len, salt_len, password, salt), packs the fields into
// zero-padded wide registers and presents them with a valid/ready handshake.
// Malformed frames are consumed without reaching the core and flagged on err_o.
module pbkdf2_loader #(
  parameter int unsigned MAX_PASS = 64,
  parameter int unsigned MAX_SALT = 63
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            data_i,
  input  logic                  v_i,
  output logic                  r_o,
  output logic [31:0]           iters_o,
  output logic [8*MAX_PASS-1:0] pass_o,
  output logic [511:0]          salt_o,
  output logic [5:0]            salt_len_o,
  output logic                  v_o,
  input  logic                  r_i,
  output logic                  err_o,
  output logic [15:0]           frames_o
);

  localparam int unsigned PW         = 8 * MAX_PASS;
  localparam int unsigned SALT_BYTES = 64;

  typedef enum logic [2:0] {
    S_HDR,
    S_PASS,
    S_SALT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [8:0]      r_cnt;
  logic [8:0]      w_cnt_next;
  logic            r_err;
  logic            w_err_next;
  logic [7:0]      r_plen;
  logic [7:0]      r_slen;
  logic [31:0]     r_iters;
  logic [PW-1:0]   r_pass;
  logic [511:0]    r_salt;
  logic [5:0]      r_salt_len;
  logic [15:0]     r_frames;
  logic            w_acc;
  logic            w_bad;
  logic [8:0]      w_drain_len;

  assign r_o        = rst_i && (r_state != S_HOLD);
  assign v_o        = (r_state == S_HOLD);
  assign err_o      = r_err;
  assign iters_o    = r_iters;
  assign pass_o     = r_pass;
  assign salt_o     = r_salt;
  assign salt_len_o = r_salt_len;
  assign frames_o   = r_frames;

  assign w_acc       = v_i && r_o;
  // Header check evaluated while byte 5 (salt_len) is on data_i; iters bytes 0-3 are already registered.
  assign w_drain_len = {1'b0, r_plen} + {1'b0, data_i};
  assign w_bad       = (r_iters == '0) || (data_i == '0) ||
                       (32'(data_i) > MAX_SALT) || (32'(r_plen) > MAX_PASS);

  // State, byte counter and error pulse registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_HDR;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
    end
  end

  // Next-state, counter and error-pulse decode
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_err_next = 1'b0;
    case (r_state)
      S_HDR: begin
        if (w_acc) begin
          if (r_cnt == 9'd5) begin
            w_cnt_next = '0;
            if (w_bad) begin
              // Nothing to drain: report immediately and stay in HDR.
              if (w_drain_len == '0) begin
                w_err_next = 1'b1;
              end else begin
                w_next     = S_DRAIN;
                w_cnt_next = w_drain_len;
              end
            end else if (r_plen == '0) begin
              w_next = S_SALT;
            end else begin
              w_next = S_PASS;
            end
          end else begin
            w_cnt_next = r_cnt + 9'd1;
          end
        end
      end
      S_PASS: begin
        if (w_acc) begin
          if (r_cnt == ({1'b0, r_plen} - 9'd1)) begin
            w_next     = S_SALT;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + 9'd1;
          end
        end
      end
      S_SALT: begin
        if (w_acc) begin
          if (r_cnt == ({1'b0, r_slen} - 9'd1)) begin
            w_next     = S_HOLD;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + 9'd1;
          end
        end
      end
      S_HOLD: begin
        if (r_i) begin
          w_next = S_HDR;
        end
      end
      S_DRAIN: begin
        if (w_acc) begin
          if (r_cnt == 9'd1) begin
            w_next     = S_HDR;
            w_cnt_next = '0;
            w_err_next = 1'b1;
          end else begin
            w_cnt_next = r_cnt - 9'd1;
          end
        end
      end
      default: begin
        w_next     = S_HDR;
        w_cnt_next = '0;
      end
    endcase
  end

  // Field packing: header byte 0 clears all fields, later bytes fill MSB-first
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_iters    <= '0;
      r_plen     <= '0;
      r_slen     <= '0;
      r_pass     <= '0;
      r_salt     <= '0;
      r_salt_len <= '0;
    end else if (w_acc) begin
      case (r_state)
        S_HDR: begin
          case (r_cnt)
            9'd0: begin
              r_iters    <= {data_i, 24'h000000};
              r_pass     <= '0;
              r_salt     <= '0;
              r_salt_len <= '0;
            end
            9'd1: r_iters[23:16] <= data_i;
            9'd2: r_iters[15:8]  <= data_i;
            9'd3: r_iters[7:0]   <= data_i;
            9'd4: r_plen         <= data_i;
            9'd5: begin
              r_slen <= data_i;
              if (!w_bad) begin
                r_salt_len <= data_i[5:0];
              end
            end
            default: ;
          endcase
        end
        S_PASS: begin
          for (int unsigned k = 0; k < MAX_PASS; k++) begin
            if (r_cnt == 9'(k)) begin
              r_pass[PW-1-8*k -: 8] <= data_i;
            end
          end
        end
        S_SALT: begin
          for (int unsigned k = 0; k < SALT_BYTES; k++) begin
            if (r_cnt == 9'(k)) begin
              r_salt[511-8*k -: 8] <= data_i;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Delivered-set counter, wraps naturally at 16 bits
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_frames <= '0;
    end else if (v_o && r_i) begin
      r_frames <= r_frames + 16'd1;
    end
  end

endmodule

// File: tb/tb_pbkdf2_loader.sv
// Self-checking bench for pbkdf2_loader: a frame-level model parses each
// sent frame into the expected parameter set; a monitor thread compares the
// DUT against it every cycle, and directed checks pin timing and literals.
module tb_pbkdf2_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0]  iters;
    logic [511:0] pass;
    logic [511:0] salt;
    logic [5:0]   slen;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [7:0]   data_i;
  logic         v_i;
  logic         r_o;
  logic [31:0]  iters_o;
  logic [511:0] pass_o;
  logic [511:0] salt_o;
  logic [5:0]   salt_len_o;
  logic         v_o;
  logic         r_i;
  logic         err_o;
  logic [15:0]  frames_o;

  int           checks = 0;
  int           errors = 0;
  int unsigned  cyc = 0;
  exp_t         expq[$];
  int           pending_err = 0;
  logic [15:0]  exp_frames = '0;
  bit           hs_prev = 1'b0;

  pbkdf2_loader #(.MAX_PASS(64), .MAX_SALT(63)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .v_i(v_i), .r_o(r_o),
    .iters_o(iters_o), .pass_o(pass_o), .salt_o(salt_o),
    .salt_len_o(salt_len_o), .v_o(v_o), .r_i(r_i), .err_o(err_o),
    .frames_o(frames_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t fill(input int n, input logic [7:0] b);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(b);
    return q;
  endfunction

  function automatic bq_t rnd(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  function automatic bq_t mk(input logic [31:0] it, input bq_t pw, input bq_t sl);
    bq_t f;
    f.push_back(it[31:24]); f.push_back(it[23:16]);
    f.push_back(it[15:8]);  f.push_back(it[7:0]);
    f.push_back(8'(pw.size()));
    f.push_back(8'(sl.size()));
    foreach (pw[i]) f.push_back(pw[i]);
    foreach (sl[i]) f.push_back(sl[i]);
    return f;
  endfunction

  // Frame-level model: parse the byte stream into what the core must receive.
  task automatic model_push(input bq_t f);
    exp_t        e;
    logic [31:0] it;
    int          p;
    int          s;
    it = {f[0], f[1], f[2], f[3]};
    p  = int'(f[4]);
    s  = int'(f[5]);
    if (it == 0 || s == 0 || s > 63 || p > 64) begin
      pending_err++;
    end else begin
      e.iters = it;
      e.pass  = '0;
      e.salt  = '0;
      for (int k = 0; k < p; k++) e.pass[511-8*k -: 8] = f[6+k];
      for (int k = 0; k < s; k++) e.salt[511-8*k -: 8] = f[6+p+k];
      e.slen  = 6'(s);
      expq.push_back(e);
    end
  endtask

  // Present bytes on negedges; a byte transfers at the next posedge when r_o is high.
  task automatic send(input bq_t f, input int limit, input bit gaps, output int unsigned t0);
    int i = 0;
    int n = 0;
    t0 = 0;
    while (i < limit) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        checks++; errors++;
        $display("FAIL send_timeout: got %0d bytes expected %0d", i, limit);
        break;
      end
      if (gaps && $urandom_range(0, 2) == 0) begin
        v_i    = 1'b0;
        data_i = 8'($urandom);
      end else begin
        v_i    = 1'b1;
        data_i = f[i];
        if (r_o) begin
          if (i == 0) t0 = cyc;
          i++;
        end
      end
    end
    if (limit == f.size()) model_push(f);
    @(negedge clk);
    v_i    = 1'b0;
    data_i = 8'h00;
  endtask

  // Called at a negedge; returns at negedge+3 with v_o high or after a bounded wait.
  task automatic wait_vo(output int unsigned at);
    #3;
    for (int w = 0; w < 100 && !v_o; w++) begin
      @(negedge clk);
      #3;
    end
    chk("wait_v_o", v_o, 1);
    at = cyc;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_r_o"}, r_o, 0);
    chk({tag, "_v_o"}, v_o, 0);
    chk({tag, "_err_o"}, err_o, 0);
    chk({tag, "_frames_o"}, frames_o, 0);
    chk({tag, "_iters_o"}, iters_o, 0);
    chk({tag, "_pass_o"}, pass_o, 0);
    chk({tag, "_salt_o"}, salt_o, 0);
    chk({tag, "_salt_len_o"}, salt_len_o, 0);
  endtask

  // Per-cycle compare against the model, sampled between drive (negedge) and the active edge.
  task automatic monitor();
    forever begin
      @(negedge clk);
      #3;
      if (!rst_i) begin
        expq.delete();
        pending_err = 0;
        exp_frames  = '0;
        hs_prev     = 1'b0;
      end else begin
        chk("r_o_vs_hold", r_o, !v_o);
        if (hs_prev) chk("v_o_drop", v_o, 0);
        chk("frames_o", frames_o, exp_frames);
        if (err_o) begin
          chk("err_o_expected", err_o, (pending_err > 0) ? 1 : 0);
          if (pending_err > 0) pending_err--;
        end
        if (v_o) begin
          if (expq.size() == 0) begin
            chk("v_o_unexpected", v_o, 0);
          end else begin
            chk("iters_o", iters_o, expq[0].iters);
            chk("pass_o", pass_o, expq[0].pass);
            chk("salt_o", salt_o, expq[0].salt);
            chk("salt_len_o", salt_len_o, expq[0].slen);
          end
        end
        hs_prev = v_o && r_i;
        if (hs_prev && expq.size() > 0) begin
          void'(expq.pop_front());
          exp_frames = exp_frames + 16'd1;
        end
      end
    end
  endtask

  task automatic bad_frame(input string tag, input bq_t f);
    int unsigned t0;
    send(f, f.size(), 1'b0, t0);
    #3;
    chk({tag, "_err_timing"}, err_o, 1);
    @(negedge clk); #3;
    chk({tag, "_err_single"}, err_o, 0);
    chk({tag, "_no_v_o"}, v_o, 0);
    @(negedge clk);
    chk({tag, "_err_consumed"}, 32'(pending_err), 0);
  endtask

  initial begin
    int unsigned  t0;
    int unsigned  at;
    bq_t          f;
    bq_t          big;
    logic [511:0] sp;
    logic [511:0] ss;
    logic [31:0]  si;
    logic [511:0] lit;

    rst_i  = 1'b0;
    v_i    = 1'b0;
    r_i    = 1'b1;
    data_i = 8'h00;
    fork
      monitor();
    join_none

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("r_o_after_reset", r_o, 1);

    // Nominal frame, full rate, latency and literal contents
    f = mk(32'h00001000, str2q("password"), str2q("salt"));
    send(f, f.size(), 1'b0, t0);
    wait_vo(at);
    chk("latency_nominal", 32'(at - t0), 18);
    chk("lit_pass_hi", pass_o[511:448], 64'h70617373776F7264);
    chk("lit_pass_lo", pass_o[447:0], 0);
    chk("lit_salt_hi", salt_o[511:480], 32'h73616C74);
    chk("lit_salt_lo", salt_o[479:0], 0);
    chk("lit_salt_len", salt_len_o, 4);
    chk("lit_iters", iters_o, 32'h00001000);
    @(negedge clk); #3;
    chk("lit_frames_1", frames_o, 1);
    chk("pass_kept_after_hs", pass_o[511:448], 64'h70617373776F7264);

    // Backpressure in HOLD
    r_i = 1'b0;
    f = mk(32'hDEADBEEF, str2q("abc"), str2q("xyz12"));
    send(f, f.size(), 1'b0, t0);
    wait_vo(at);
    sp = pass_o; ss = salt_o; si = iters_o;
    repeat (10) begin
      @(negedge clk);
      v_i = 1'b1; data_i = 8'h5A;
      #3;
      chk("bp_r_o", r_o, 0);
      chk("bp_v_o", v_o, 1);
      chk("bp_pass_stable", pass_o, sp);
      chk("bp_salt_stable", salt_o, ss);
      chk("bp_iters_stable", iters_o, si);
    end
    @(negedge clk);
    v_i = 1'b0; r_i = 1'b1;
    @(negedge clk); #3;
    chk("bp_r_o_after_hs", r_o, 1);
    chk("bp_frames_2", frames_o, 2);

    // P = 0, S = 63: password phase skipped
    f = mk(32'h00000001, fill(0, 8'h00), fill(63, 8'hA5));
    send(f, f.size(), 1'b0, t0);
    wait_vo(at);
    chk("latency_p0", 32'(at - t0), 69);
    lit = {{63{8'hA5}}, 8'h00};
    chk("lit_p0_salt", salt_o, lit);
    chk("lit_p0_pass", pass_o, 0);
    chk("lit_p0_salt_len", salt_len_o, 63);

    // Malformed frames
    @(negedge clk);
    bad_frame("bad_iters0", mk(32'h00000000, str2q("pw"), str2q("abc")));
    bad_frame("bad_s64", mk(32'h00000010, str2q("q"), fill(64, 8'h3C)));
    bad_frame("bad_p0s0", mk(32'h00000010, fill(0, 8'h00), fill(0, 8'h00)));
    bad_frame("bad_p65", mk(32'h00000010, fill(65, 8'h11), str2q("z")));
    chk("bad_frames_unchanged", frames_o, 3);
    f = mk(32'h12345678, str2q("hunter2"), str2q("NaCl"));
    send(f, f.size(), 1'b0, t0);
    wait_vo(at);
    chk("after_bad_latency", 32'(at - t0), 17);

    // P = 64, S = 16 at full rate and with random v_i gaps
    @(negedge clk);
    big = mk(32'hCAFEF00D, rnd(64), rnd(16));
    send(big, big.size(), 1'b0, t0);
    wait_vo(at);
    chk("latency_p64", 32'(at - t0), 86);
    @(negedge clk);
    send(big, big.size(), 1'b1, t0);
    wait_vo(at);
    @(negedge clk); #3;
    chk("frames_6", frames_o, 6);

    // Reset mid-frame at byte 20
    @(negedge clk);
    send(big, 20, 1'b0, t0);
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk); #1;
    chk_zero("midreset");
    @(negedge clk);
    rst_i = 1'b1;
    f = mk(32'h00000003, str2q("k"), str2q("s"));
    send(f, f.size(), 1'b0, t0);
    wait_vo(at);
    @(negedge clk); #3;
    chk("frames_after_reset", frames_o, 1);

    // Counter wrap
    @(negedge clk);
    force dut.r_frames = 16'hFFFF;
    exp_frames = 16'hFFFF;
    @(negedge clk);
    release dut.r_frames;
    #1;
    chk("frames_preset", frames_o, 16'hFFFF);
    send(f, f.size(), 1'b0, t0);
    wait_vo(at);
    @(negedge clk); #3;
    chk("frames_wrap_0", frames_o, 0);
    @(negedge clk);
    send(f, f.size(), 1'b0, t0);
    wait_vo(at);
    @(negedge clk); #3;
    chk("frames_wrap_1", frames_o, 1);

    repeat (3) @(negedge clk);
    chk("model_queue_empty", 32'(expq.size()), 0);
    chk("model_err_empty", 32'(pending_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
